out_col_scheduler: RTL

Round-robin write scheduler between the per-column MLP result buffers and the single output NAP (AXI4 master side to GDDR). Each column buffer raises a ready flag when it holds at least one full burst. The scheduler then grants one column at a time and issues the AXI write address. It streams exactly one burst of that column's data on the W channel and tracks outstanding write responses. It sits between the column result buffers and `nap_out`, and provides the idle/error status that feeds the top-level done and error pins.

---
 rtl/out_col_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/out_col_scheduler.sv
// Round-robin AXI4 write scheduler: drains one full burst at a time from the column
// result buffers to the output NAP. Optional per-column burst counters: OUT_SCHED_STATS_EN.
module out_col_scheduler #(
    parameter int         NUM_COLS        = 4,
    parameter int         DATA_WIDTH      = 256,
    parameter int         BURST_LEN       = 16,
    parameter int         GDDR_ADDR_WIDTH = 30,
    parameter logic [8:0] GDDR_ADDR_ID    = 9'h000,
    parameter int         MAX_OUTSTANDING = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_frame_start,
    input  logic [NUM_COLS-1:0]            i_col_burst_ready,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] i_col_data,
    output logic [NUM_COLS-1:0]            o_col_pop,
    output logic [NUM_COLS-1:0]            o_col_grant,
    output logic                           o_awvalid,
    input  logic                           i_awready,
    output logic [41:0]                    o_awaddr,
    output logic [7:0]                     o_awlen,
    output logic                           o_wvalid,
    input  logic                           i_wready,
    output logic [DATA_WIDTH-1:0]          o_wdata,
    output logic                           o_wlast,
    input  logic                           i_bvalid,
    input  logic [1:0]                     i_bresp,
    output logic                           o_bready,
    output logic                           o_idle,
    output logic                           o_bresp_error,
    output logic [NUM_COLS*16-1:0]         o_burst_cnt
);
    localparam int COL_W       = $clog2(NUM_COLS);
    localparam int OFF_W       = GDDR_ADDR_WIDTH - COL_W;
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [OFF_W-1:0] PTR_INC   = OFF_W'(BURST_BYTES);
    localparam logic [7:0]       LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t                r_state, w_state_next;
    logic [COL_W-1:0]      r_grant_idx;
    logic [COL_W-1:0]      r_last_idx;
    logic [7:0]            r_beat;
    logic [OUT_W-1:0]      r_outstanding;
    logic                  r_rewind_pend;
    logic                  r_bresp_err;
    logic                  r_idle;
    logic                  w_arb_found;
    logic [COL_W-1:0]      w_arb_idx;
    logic                  w_aw_hs, w_w_hs, w_last_hs, w_b_dec, w_rewind;
    logic [NUM_COLS-1:0]   w_grant_oh;
    logic [NUM_COLS*OFF_W-1:0] w_ptr_flat;

    // Search wraps naturally because NUM_COLS is a power of two; i==NUM_COLS revisits last.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_last_idx;
        for (int i = 1; i <= NUM_COLS; i++) begin
            if (!w_arb_found && i_col_burst_ready[r_last_idx + COL_W'(i)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = r_last_idx + COL_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_arb_found && (r_outstanding < OUT_MAX)) w_state_next = S_ADDR;
            S_ADDR: if (i_awready) w_state_next = S_DATA;
            S_DATA: if (w_last_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_aw_hs    = (r_state == S_ADDR) && i_awready;
    assign w_w_hs     = (r_state == S_DATA) && i_wready;
    assign w_last_hs  = w_w_hs && (r_beat == LAST_BEAT);
    assign w_b_dec    = i_bvalid && ((r_outstanding != '0) || w_aw_hs);
    assign w_rewind   = (r_state == S_IDLE) && (i_frame_start || r_rewind_pend);
    assign w_grant_oh = (r_state != S_IDLE) ? (NUM_COLS'(1) << r_grant_idx) : '0;

    assign o_awvalid     = (r_state == S_ADDR);
    assign o_awaddr      = o_awvalid ? {GDDR_ADDR_ID, 3'b000, r_grant_idx,
                                        w_ptr_flat[r_grant_idx*OFF_W +: OFF_W]} : '0;
    assign o_awlen       = o_awvalid ? LAST_BEAT : 8'h00;
    assign o_wvalid      = (r_state == S_DATA);
    assign o_wdata       = o_wvalid ? i_col_data[r_grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_wlast       = o_wvalid && (r_beat == LAST_BEAT);
    assign o_col_grant   = w_grant_oh;
    assign o_col_pop     = w_w_hs ? w_grant_oh : '0;
    assign o_bready      = 1'b1;
    assign o_idle        = r_idle;
    assign o_bresp_error = r_bresp_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_grant_idx   <= '0;
            r_last_idx    <= COL_W'(NUM_COLS - 1);
            r_beat        <= '0;
            r_outstanding <= '0;
            r_rewind_pend <= 1'b0;
            r_bresp_err   <= 1'b0;
            r_idle        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && (w_state_next == S_ADDR)) begin
                r_grant_idx <= w_arb_idx;
                r_last_idx  <= w_arb_idx;
            end
            if (w_w_hs) r_beat <= w_last_hs ? 8'h00 : r_beat + 8'h01;
            if (w_aw_hs && !w_b_dec)      r_outstanding <= r_outstanding + OUT_W'(1);
            else if (!w_aw_hs && w_b_dec) r_outstanding <= r_outstanding - OUT_W'(1);
            // A rewind requested mid-burst waits so the in-flight address stays valid.
            if (r_state == S_IDLE)  r_rewind_pend <= 1'b0;
            else if (i_frame_start) r_rewind_pend <= 1'b1;
            if (i_bvalid && (i_bresp != 2'b00)) r_bresp_err <= 1'b1;
            r_idle <= (r_state == S_IDLE) && (r_outstanding == '0) && (i_col_burst_ready == '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col_ptr
            logic [OFF_W-1:0] r_ptr;
            always_ff @(posedge i_clk) begin
                if (i_reset || w_rewind)                      r_ptr <= '0;
                else if (w_aw_hs && (r_grant_idx == COL_W'(gi))) r_ptr <= r_ptr + PTR_INC;
            end
            assign w_ptr_flat[gi*OFF_W +: OFF_W] = r_ptr;
        end
    endgenerate

`ifdef OUT_SCHED_STATS_EN
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge i_clk) begin
                if (i_reset || i_frame_start) r_cnt <= 16'h0000;
                else if (w_last_hs && (r_grant_idx == COL_W'(gi)) && (r_cnt != 16'hFFFF))
                    r_cnt <= r_cnt + 16'h0001;
            end
            assign o_burst_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`else
    assign o_burst_cnt = '0;
`endif

endmodule
